// File: rtl/basic_bus_out_queue.sv
// Decoupling FIFO for one output port of the 4x4 basic message bus.
// Define BASIC_BUS_QUEUE_FLOW_EN to let a message pass straight through when the queue is empty.
module basic_bus_out_queue #(
  parameter int DEPTH        = 2,
  parameter int ADDR_BLOCK_W = 26,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    io_enq_ready,
  input  logic                    io_enq_valid,
  input  logic [1:0]              io_enq_bits_header_src,
  input  logic [1:0]              io_enq_bits_header_dst,
  input  logic [ADDR_BLOCK_W-1:0] io_enq_bits_payload_addr_block,
  input  logic [1:0]              io_enq_bits_payload_p_type,
  input  logic                    io_deq_ready,
  output logic                    io_deq_valid,
  output logic [1:0]              io_deq_bits_header_src,
  output logic [1:0]              io_deq_bits_header_dst,
  output logic [ADDR_BLOCK_W-1:0] io_deq_bits_payload_addr_block,
  output logic [1:0]              io_deq_bits_payload_p_type,
  output logic [CNT_W-1:0]        io_count
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 6 + ADDR_BLOCK_W;

  logic [ENTRY_W-1:0] entry_reg [DEPTH];
  logic [DEPTH-1:0]   wr_en;

  logic [PTR_W-1:0] enq_ptr_reg, enq_ptr_next;
  logic [PTR_W-1:0] deq_ptr_reg, deq_ptr_next;
  logic             maybe_full_reg, maybe_full_next;

  logic               ptr_match;
  logic               empty;
  logic               full;
  logic               bypass;
  logic               do_enq;
  logic               do_deq;
  logic [ENTRY_W-1:0] enq_word;
  logic [ENTRY_W-1:0] head_word;
  logic [ENTRY_W-1:0] deq_word;

  // Pointers wrap explicitly so any DEPTH works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1))
      return '0;
    return p + PTR_W'(1);
  endfunction

  assign enq_word = {io_enq_bits_header_src, io_enq_bits_header_dst,
                     io_enq_bits_payload_addr_block, io_enq_bits_payload_p_type};

  assign ptr_match = (enq_ptr_reg == deq_ptr_reg);
  assign empty     = ptr_match & ~maybe_full_reg;
  assign full      = ptr_match &  maybe_full_reg;

`ifdef BASIC_BUS_QUEUE_FLOW_EN
  assign bypass       = empty & io_enq_valid & io_deq_ready;
  assign io_deq_valid = ~empty | io_enq_valid;
  assign deq_word     = empty ? enq_word : head_word;
`else
  assign bypass       = 1'b0;
  assign io_deq_valid = ~empty;
  assign deq_word     = head_word;
`endif

  // Enqueue readiness depends only on stored state, never on the client's ready.
  assign io_enq_ready = ~full;
  assign do_enq       = io_enq_valid & ~full & ~bypass;
  assign do_deq       = ~empty & io_deq_ready;

  assign {io_deq_bits_header_src, io_deq_bits_header_dst,
          io_deq_bits_payload_addr_block, io_deq_bits_payload_p_type} = deq_word;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_enq & (enq_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Payload storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i])
        entry_reg[i] <= enq_word;
    end
  end

  always_comb begin
    head_word = entry_reg[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (deq_ptr_reg == PTR_W'(i))
        head_word = entry_reg[i];
    end
  end

  always_comb begin
    enq_ptr_next    = enq_ptr_reg;
    deq_ptr_next    = deq_ptr_reg;
    maybe_full_next = maybe_full_reg;
    if (do_enq)
      enq_ptr_next = ptr_inc(enq_ptr_reg);
    if (do_deq)
      deq_ptr_next = ptr_inc(deq_ptr_reg);
    if (do_enq != do_deq)
      maybe_full_next = do_enq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr_reg    <= '0;
      deq_ptr_reg    <= '0;
      maybe_full_reg <= 1'b0;
    end else begin
      enq_ptr_reg    <= enq_ptr_next;
      deq_ptr_reg    <= deq_ptr_next;
      maybe_full_reg <= maybe_full_next;
    end
  end

  always_comb begin
    if (full)
      io_count = CNT_W'(DEPTH);
    else if (enq_ptr_reg >= deq_ptr_reg)
      io_count = CNT_W'(enq_ptr_reg) - CNT_W'(deq_ptr_reg);
    else
      io_count = CNT_W'(DEPTH) - CNT_W'(deq_ptr_reg) + CNT_W'(enq_ptr_reg);
  end

endmodule

// File: tb/tb_basic_bus_out_queue.sv
// Bench for basic_bus_out_queue: a DEPTH=2 and a DEPTH=3 instance, vector table,
// hand sequences and randomized traffic against a queue-based reference model.
module tb_basic_bus_out_queue;

`ifdef BASIC_BUS_QUEUE_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev [2];
  logic [31:0] ew [2];
  logic        dr [2];
  logic        er [2];
  logic        dv [2];
  logic [1:0]  ds [2];
  logic [1:0]  dd [2];
  logic [25:0] da [2];
  logic [1:0]  dp [2];
  logic [31:0] dw [2];
  logic [1:0]  cnt [2];

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  basic_bus_out_queue #(.DEPTH(2), .ADDR_BLOCK_W(26)) u_dut2 (
    .clk(clk), .reset(rst_n),
    .io_enq_ready(er[0]), .io_enq_valid(ev[0]),
    .io_enq_bits_header_src(ew[0][31:30]), .io_enq_bits_header_dst(ew[0][29:28]),
    .io_enq_bits_payload_addr_block(ew[0][27:2]), .io_enq_bits_payload_p_type(ew[0][1:0]),
    .io_deq_ready(dr[0]), .io_deq_valid(dv[0]),
    .io_deq_bits_header_src(ds[0]), .io_deq_bits_header_dst(dd[0]),
    .io_deq_bits_payload_addr_block(da[0]), .io_deq_bits_payload_p_type(dp[0]),
    .io_count(cnt[0])
  );

  basic_bus_out_queue #(.DEPTH(3), .ADDR_BLOCK_W(26)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .io_enq_ready(er[1]), .io_enq_valid(ev[1]),
    .io_enq_bits_header_src(ew[1][31:30]), .io_enq_bits_header_dst(ew[1][29:28]),
    .io_enq_bits_payload_addr_block(ew[1][27:2]), .io_enq_bits_payload_p_type(ew[1][1:0]),
    .io_deq_ready(dr[1]), .io_deq_valid(dv[1]),
    .io_deq_bits_header_src(ds[1]), .io_deq_bits_header_dst(dd[1]),
    .io_deq_bits_payload_addr_block(da[1]), .io_deq_bits_payload_p_type(dp[1]),
    .io_count(cnt[1])
  );

  assign dw[0] = {ds[0], dd[0], da[0], dp[0]};
  assign dw[1] = {ds[1], dd[1], da[1], dp[1]};

  typedef struct {
    logic        ev;
    logic [31:0] ew;
    logic        dr;
    logic        exp_er;
    logic        exp_dv;
    logic [1:0]  exp_cnt;
    logic        chk_w;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int src, input int dst, input int addr, input int pt);
    logic [31:0] w;
    w = {src[1:0], dst[1:0], addr[25:0], pt[1:0]};
    return w;
  endfunction

  // One clock cycle on instance k, checked against the reference queue of that instance.
  task automatic cycle_model(input int k, input logic ev_i, input logic [31:0] w_i, input logic dr_i);
    int          size;
    int          depth;
    logic [31:0] head;
    depth = (k == 0) ? 2 : 3;
    size  = (k == 0) ? q0.size() : q1.size();
    head  = '0;
    if (size > 0)
      head = (k == 0) ? q0[0] : q1[0];
    ev[k] = ev_i; ew[k] = w_i; dr[k] = dr_i;
    #3;
    check($sformatf("q%0d enq_ready", k), {31'd0, er[k]}, {31'd0, size < depth});
    check($sformatf("q%0d deq_valid", k), {31'd0, dv[k]}, {31'd0, (size > 0) || (FLOW && ev_i)});
    check($sformatf("q%0d count", k), {30'd0, cnt[k]}, size);
    if (size > 0)
      check($sformatf("q%0d deq_bits", k), dw[k], head);
    else if (FLOW && ev_i)
      check($sformatf("q%0d flow_bits", k), dw[k], w_i);
    if (!(FLOW && size == 0 && ev_i && dr_i)) begin
      if (size > 0 && dr_i) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (ev_i && size < depth) begin
        if (k == 0) q0.push_back(w_i); else q1.push_back(w_i);
      end
    end
    @(posedge clk);
    #1;
    ev[k] = 1'b0; dr[k] = 1'b0; ew[k] = '0;
  endtask

  initial begin
    logic [31:0] a, b, c;
    logic [31:0] got [$];
    int          p_enq, p_deq;

    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0; ew[k] = '0; dr[k] = 1'b0;
    end

    // Reset held for three cycles, released away from the edge.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst q%0d enq_ready", k), {31'd0, er[k]}, 32'd1);
      check($sformatf("rst q%0d deq_valid", k), {31'd0, dv[k]}, 32'd0);
      check($sformatf("rst q%0d count", k), {30'd0, cnt[k]}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst enq_ready", {31'd0, er[0]}, 32'd1);
    check("post_rst deq_valid", {31'd0, dv[0]}, 32'd0);

    // Fill/full/drain on DEPTH=2; C held valid while full.
    a = mk(0, 1, 'h0000123, 2);
    b = mk(1, 1, 'h0000456, 1);
    c = mk(2, 1, 'h0000789, 3);
    vecs[0] = '{1'b1, a,     1'b0, 1'b1, FLOW, 2'd0, 1'b0, '0};
    vecs[1] = '{1'b1, b,     1'b0, 1'b1, 1'b1, 2'd1, 1'b1, a};
    vecs[2] = '{1'b1, c,     1'b0, 1'b0, 1'b1, 2'd2, 1'b1, a};
    vecs[3] = '{1'b1, c,     1'b0, 1'b0, 1'b1, 2'd2, 1'b1, a};
    vecs[4] = '{1'b1, c,     1'b1, 1'b0, 1'b1, 2'd2, 1'b1, a};
    vecs[5] = '{1'b1, c,     1'b0, 1'b1, 1'b1, 2'd1, 1'b1, b};
    vecs[6] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, b};
    vecs[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, c};
    vecs[8] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, '0};
    for (int i = 0; i < 9; i++) begin
      ev[0] = vecs[i].ev; ew[0] = vecs[i].ew; dr[0] = vecs[i].dr;
      #3;
      check($sformatf("vec%0d enq_ready", i), {31'd0, er[0]}, {31'd0, vecs[i].exp_er});
      check($sformatf("vec%0d deq_valid", i), {31'd0, dv[0]}, {31'd0, vecs[i].exp_dv});
      check($sformatf("vec%0d count", i), {30'd0, cnt[0]}, {30'd0, vecs[i].exp_cnt});
      if (vecs[i].chk_w)
        check($sformatf("vec%0d deq_bits", i), dw[0], vecs[i].exp_w);
      @(posedge clk);
      #1;
    end
    ev[0] = 1'b0; dr[0] = 1'b0;

    // Streaming: enq and deq every cycle, addr = i.
    for (int i = 0; i <= 20; i++) begin
      ev[0] = (i < 20); ew[0] = mk(3, 1, i, 0); dr[0] = 1'b1;
      #3;
      if (dv[0])
        got.push_back(dw[0]);
      if (i >= 1 && i <= 19) begin
        check($sformatf("stream%0d count", i), {30'd0, cnt[0]}, FLOW ? 32'd0 : 32'd1);
        check($sformatf("stream%0d deq_valid", i), {31'd0, dv[0]}, 32'd1);
      end
      @(posedge clk);
      #1;
    end
    ev[0] = 1'b0; dr[0] = 1'b0;
    check("stream received", got.size(), 32'd20);
    for (int i = 0; i < got.size() && i < 20; i++)
      check($sformatf("stream addr%0d", i), {6'd0, got[i][27:2]}, i);

    // DEPTH=3 pointer wrap: two preloaded, seven enq/deq pairs with stalls, drain.
    cycle_model(1, 1'b1, mk(0, 2, 100, 1), 1'b0);
    cycle_model(1, 1'b1, mk(1, 2, 101, 2), 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle_model(1, 1'b1, mk(i % 4, 2, 102 + i, i % 4), 1'b1);
      cycle_model(1, 1'b0, '0, 1'b0);
    end
    repeat (3) cycle_model(1, 1'b0, '0, 1'b1);

    // Randomized traffic with varying enq/deq pressure on both depths.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 300; n++) begin
        p_enq = (n < 100) ? 80 : (n < 200) ? 30 : 60;
        p_deq = (n < 100) ? 30 : (n < 200) ? 80 : 60;
        cycle_model(k, $urandom_range(0, 99) < p_enq, $urandom, $urandom_range(0, 99) < p_deq);
      end
    end

    // Asynchronous reset with two entries held.
    while (q0.size() > 0)
      cycle_model(0, 1'b0, '0, 1'b1);
    cycle_model(0, 1'b1, mk(1, 1, 'h55, 1), 1'b0);
    cycle_model(0, 1'b1, mk(2, 1, 'h66, 2), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst deq_valid", {31'd0, dv[0]}, 32'd0);
    check("async_rst count", {30'd0, cnt[0]}, 32'd0);
    check("async_rst enq_ready", {31'd0, er[0]}, 32'd1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle_model(0, 1'b0, '0, 1'b1);
    cycle_model(1, 1'b0, '0, 1'b1);

`ifdef BASIC_BUS_QUEUE_FLOW_EN
    cycle_model(0, 1'b1, mk(2, 3, 'h3abcdef, 1), 1'b1);
    cycle_model(0, 1'b0, '0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
